// File: rtl/fcmp_arb_pkg.sv
// Shared types for the arbitrated single-precision compare block.
package fcmp_pkg;

    localparam int DEFAULT_NREQ = 2;

    // Opcode carried with each request; FCMP_RSV returns an error result.
    typedef enum logic [1:0] {
        FCMP_EQ  = 2'd0,
        FCMP_LT  = 2'd1,
        FCMP_LE  = 2'd2,
        FCMP_RSV = 2'd3
    } fcmp_op_t;

    // One compare request as held in the first pipeline stage.
    typedef struct packed {
        fcmp_op_t    op;
        logic [31:0] x;
        logic [31:0] y;
    } fcmp_req_t;

    // Requester tag width; a single bit even for the degenerate case.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fcmp_arb_if.sv
// Request and result streams between the issue ports and the shared comparator.
interface fcmp_arb_if import fcmp_pkg::*; #(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int IDW  = id_width(NREQ)
) ();

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][1:0]  req_op;
    logic [NREQ-1:0][31:0] req_x;
    logic [NREQ-1:0][31:0] req_y;

    logic                  res_valid;
    logic                  res_ready;
    logic [IDW-1:0]        res_id;
    logic                  res_z;
    logic                  res_err;

    // Requesters plus the result consumer.
    modport master (
        output req_valid, req_op, req_x, req_y, res_ready,
        input  req_ready, res_valid, res_id, res_z, res_err
    );

    // The arbitrated comparator.
    modport slave (
        input  req_valid, req_op, req_x, req_y, res_ready,
        output req_ready, res_valid, res_id, res_z, res_err
    );

endinterface

// File: rtl/fcmp_arb_core.sv
// Combinational raw-bit single-precision compare; no NaN or signed-zero folding.
module fcmp_core import fcmp_pkg::*; (
    input  fcmp_op_t    op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        z,
    output logic        err
);

    logic w_eq;
    logic w_lt;

    // Exponent sits above mantissa, so {e,m} orders like one magnitude field.
    always_comb begin
        w_eq = (x == y);
        if (x[31] != y[31]) begin
            w_lt = x[31];
        end else if (!x[31]) begin
            w_lt = (x[30:0] < y[30:0]);
        end else begin
            w_lt = (x[30:0] > y[30:0]);
        end
    end

    // Select the result for the opcode; reserved opcode flags an error.
    always_comb begin
        // NOTE: default every output first so no path leaves one unassigned (no latch).
        z   = 1'b0;
        err = 1'b0;
        case (op)
            FCMP_EQ:  z = w_eq;
            FCMP_LT:  z = w_lt;
            FCMP_LE:  z = w_lt | w_eq;
            default:  err = 1'b1;
        endcase
    end

endmodule

// File: rtl/fcmp_arb.sv
// Round-robin shared compare datapath: NREQ request ports, one tagged result stream,
// two registered stages with the comparator between them.
module fcmp_arb import fcmp_pkg::*; #(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int IDW  = id_width(NREQ)
) (
    input logic       clk,
    input logic       rstn,
    fcmp_arb_if.slave bus
);

    logic [IDW-1:0]  r_last;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_gidx;
    logic [IDW-1:0]  w_idx;
    logic            w_any;

    logic            w_s1_en;
    logic            w_s2_en;
    logic            w_accept;

    logic            r_s1_v;
    fcmp_req_t       r_s1_req;
    logic [IDW-1:0]  r_s1_id;

    logic            r_s2_v;
    logic            r_s2_z;
    logic            r_s2_err;
    logic [IDW-1:0]  r_s2_id;

    logic            w_core_z;
    logic            w_core_err;

    // Round-robin pick: first valid requester searching from last+1, wrapping.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_idx   = '0;
        w_any   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IDW'((int'(r_last) + k) % NREQ);
            if (!w_any && bus.req_valid[w_idx]) begin
                w_any          = 1'b1;
                w_gidx         = w_idx;
                w_grant[w_idx] = 1'b1;
            end
        end
    end

    // A stage may load when it is empty or its contents move on this edge.
    assign w_s2_en       = !r_s2_v || bus.res_ready;
    assign w_s1_en       = !r_s1_v || w_s2_en;
    assign w_accept      = w_any && w_s1_en && rstn;
    assign bus.req_ready = w_grant & {NREQ{w_s1_en && rstn}};

    // Pointer advances only on a completed request handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            r_last <= IDW'(NREQ - 1);
        end else if (w_accept) begin
            r_last <= w_gidx;
        end
    end

    // Stage 1: capture the granted request operands and its tag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_v   <= 1'b0;
            r_s1_req <= '0;
            r_s1_id  <= '0;
        end else if (w_s1_en) begin
            r_s1_v <= w_accept;
            if (w_accept) begin
                r_s1_req <= '{op: fcmp_op_t'(bus.req_op[w_gidx]),
                              x:  bus.req_x[w_gidx],
                              y:  bus.req_y[w_gidx]};
                r_s1_id  <= w_gidx;
            end
        end
    end

    fcmp_core u_core (
        .op  (r_s1_req.op),
        .x   (r_s1_req.x),
        .y   (r_s1_req.y),
        .z   (w_core_z),
        .err (w_core_err)
    );

    // Stage 2: register the compare result; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s2_v   <= 1'b0;
            r_s2_z   <= 1'b0;
            r_s2_err <= 1'b0;
            r_s2_id  <= '0;
        end else if (w_s2_en) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_z   <= w_core_z;
                r_s2_err <= w_core_err;
                r_s2_id  <= r_s1_id;
            end
        end
    end

    assign bus.res_valid = r_s2_v;
    assign bus.res_z     = r_s2_z;
    assign bus.res_err   = r_s2_err;
    assign bus.res_id    = r_s2_id;

endmodule

// File: tb/tb_fcmp_arb.sv
// Scoreboard bench for fcmp_arb: queue-based requesters, arbitration model,
// spec-level compare model, directed scenarios then a randomized run.
module tb_fcmp_arb;
    import fcmp_pkg::*;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           z;
        logic           err;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    fcmp_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    fcmp_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    fcmp_req_t rq [NREQ][$];
    exp_t      sb [$];
    int        pop_ids [$];
    int        pop_cycles [$];
    bit        pending [NREQ];

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int acc_count = 0;
    int m_last    = NREQ - 1;
    bit gap_en    = 1'b0;
    int rr_mode   = 1;       // 0: res_ready low, 1: high, 2: random
    bit hold_v    = 1'b0;
    exp_t hold_val;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare rules stated on sign / exponent / mantissa fields.
    function automatic exp_t ref_model(input fcmp_req_t r, input int id);
        exp_t        e;
        bit          sx, sy, eq, lt;
        logic [7:0]  ex, ey;
        logic [22:0] mx, my;
        sx = r.x[31];     sy = r.y[31];
        ex = r.x[30:23];  ey = r.y[30:23];
        mx = r.x[22:0];   my = r.y[22:0];
        eq = (r.x == r.y);
        lt = (sx && !sy)
          || (!sx && !sy && ((ex < ey) || (ex == ey && mx < my)))
          || (sx && sy && ((ex > ey) || (ex == ey && mx > my)));
        e.id  = IDW'(id);
        e.err = 1'b0;
        case (r.op)
            FCMP_EQ: e.z = eq;
            FCMP_LT: e.z = lt;
            FCMP_LE: e.z = lt || eq;
            default: begin e.z = 1'b0; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    function automatic int expected_winner(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (last + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic int total_queued();
        int s = 0;
        for (int i = 0; i < NREQ; i++) s += rq[i].size();
        return s;
    endfunction

    // Requester and consumer driver: inputs change only at the falling edge.
    always @(negedge clk) begin
        case (rr_mode)
            0:       bus.res_ready = 1'b0;
            1:       bus.res_ready = 1'b1;
            default: bus.res_ready = 1'($urandom_range(0, 1));
        endcase
        if (!rstn) begin
            for (int i = 0; i < NREQ; i++) begin
                pending[i]       = 1'b0;
                bus.req_valid[i] = 1'b1;
                bus.req_op[i]    = 2'($urandom);
                bus.req_x[i]     = $urandom;
                bus.req_y[i]     = $urandom;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pending[i]) begin
                    if (rq[i].size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
                        bus.req_valid[i] = 1'b1;
                        bus.req_op[i]    = rq[i][0].op;
                        bus.req_x[i]     = rq[i][0].x;
                        bus.req_y[i]     = rq[i][0].y;
                        pending[i]       = 1'b1;
                    end else begin
                        bus.req_valid[i] = 1'b0;
                    end
                end
            end
            #2;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i] && rq[i].size() > 0) begin
                    void'(rq[i].pop_front());
                    pending[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: handshakes seen here complete at the next rising edge.
    always @(negedge clk) begin
        logic [NREQ-1:0] acc;
        logic [NREQ-1:0] exp_mask;
        exp_t            e;
        int              w;
        #1;
        if (!rstn) begin
            hold_v = 1'b0;
        end else begin
            acc = bus.req_valid & bus.req_ready;
            if (bus.req_valid != '0)
                check("ready_onehot0", 64'($countones(bus.req_ready) <= 1), 64'd1);
            if (acc != '0) begin
                w        = expected_winner(bus.req_valid, m_last);
                exp_mask = '0;
                if (w >= 0) exp_mask[w] = 1'b1;
                check("arb_pick", acc, exp_mask);
                for (int i = 0; i < NREQ; i++) begin
                    if (acc[i] && rq[i].size() > 0) begin
                        sb.push_back(ref_model(rq[i][0], i));
                        m_last = i;
                    end
                end
                acc_count++;
            end
            if (hold_v) begin
                check("res_hold_valid", bus.res_valid, 1'b1);
                check("res_hold_data", {bus.res_id, bus.res_z, bus.res_err}, hold_val);
            end
            hold_v   = bus.res_valid && !bus.res_ready;
            hold_val = {bus.res_id, bus.res_z, bus.res_err};
            if (bus.res_valid && bus.res_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got id=%0d z=%0b with empty scoreboard (cycle %0d)",
                             bus.res_id, bus.res_z, cyc);
                end else begin
                    e = sb.pop_front();
                    check("res_id",  bus.res_id,  e.id);
                    check("res_z",   bus.res_z,   e.z);
                    check("res_err", bus.res_err, e.err);
                end
                pop_ids.push_back(int'(bus.res_id));
                pop_cycles.push_back(cyc);
            end
        end
    end

    task automatic push_req(input int id, input fcmp_op_t op, input logic [31:0] x, input logic [31:0] y);
        fcmp_req_t r;
        r.op = op; r.x = x; r.y = y;
        rq[id].push_back(r);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((total_queued() > 0 || sb.size() > 0 || bus.res_valid) && n < budget) begin
            @(negedge clk); #3;
            n++;
        end
        check({name, "_drain_in_time"}, 64'(n < budget), 64'd1);
        check({name, "_scoreboard_empty"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] x, y;
        int          n;
        int          acc0;

        // Reset values, with every requester asserting valid.
        repeat (3) @(negedge clk);
        #3;
        check("rst_res_valid", bus.res_valid, 1'b0);
        check("rst_res_z",     bus.res_z,     1'b0);
        check("rst_res_err",   bus.res_err,   1'b0);
        check("rst_res_id",    bus.res_id,    '0);
        check("rst_req_ready", bus.req_ready, '0);
        @(posedge clk); #1 rstn = 1'b1;

        // Single EQ with latency check.
        push_req(0, FCMP_EQ, 32'h3F80_0000, 32'h3F80_0000);
        n = 0;
        do begin
            @(negedge clk); #3;
            n++;
        end while (!(bus.req_valid[0] && bus.req_ready[0]) && n < 20);
        check("eq_accept_seen", 64'(n < 20), 64'd1);
        @(negedge clk); #3;
        check("eq_lat_stage1_only", bus.res_valid, 1'b0);
        @(negedge clk); #3;
        check("eq_lat_res_valid", bus.res_valid, 1'b1);
        check("eq_res_id",        bus.res_id,    '0);
        check("eq_res_z",         bus.res_z,     1'b1);
        check("eq_res_err",       bus.res_err,   1'b0);
        drain("eq", 50);

        // Sign cases back-to-back on requester 1.
        pop_cycles.delete();
        push_req(1, FCMP_LT, 32'hBF80_0000, 32'h3F80_0000);
        push_req(1, FCMP_LT, 32'hC000_0000, 32'hBF80_0000);
        push_req(1, FCMP_LE, 32'h4000_0000, 32'h4000_0000);
        drain("sign", 50);
        check("sign_count", 64'(pop_cycles.size()), 64'd3);
        if (pop_cycles.size() == 3) begin
            check("sign_thru_1", 64'(pop_cycles[1] - pop_cycles[0]), 64'd1);
            check("sign_thru_2", 64'(pop_cycles[2] - pop_cycles[1]), 64'd1);
        end

        // Fairness with both requesters continuously valid.
        pop_ids.delete();
        for (int k = 0; k < 3; k++) begin
            push_req(0, FCMP_EQ, 32'h0000_0000, 32'h8000_0000);
            push_req(1, FCMP_LT, 32'h8000_0000, 32'h0000_0000);
        end
        drain("fair", 60);
        check("fair_count", 64'(pop_ids.size()), 64'd6);
        for (int k = 0; k < 6 && k < pop_ids.size(); k++)
            check("fair_id_seq", 64'(pop_ids[k]), 64'(k % 2));

        // Backpressure: consumer stalled, both requesters valid.
        rr_mode = 0;
        @(negedge clk); #3;
        acc0 = acc_count;
        for (int k = 0; k < 4; k++) begin
            push_req(0, FCMP_LE, $urandom, $urandom);
            push_req(1, FCMP_LT, $urandom, $urandom);
        end
        repeat (5) @(negedge clk);
        #3;
        check("bp_accepts", 64'(acc_count - acc0), 64'd2);
        check("bp_req_ready_zero", bus.req_ready, '0);
        check("bp_res_valid", bus.res_valid, 1'b1);
        rr_mode = 1;
        drain("bp", 100);

        // Reserved opcode.
        push_req(0, FCMP_RSV, 32'h3F80_0000, 32'h3F80_0000);
        drain("rsv", 50);

        // Asynchronous reset with both stages full.
        rr_mode = 0;
        for (int k = 0; k < 3; k++) begin
            push_req(0, FCMP_EQ, $urandom, $urandom);
            push_req(1, FCMP_EQ, $urandom, $urandom);
        end
        repeat (4) @(negedge clk);
        #3;
        check("pre_reset_full", bus.res_valid, 1'b1);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        check("async_rst_res_valid", bus.res_valid, 1'b0);
        check("async_rst_res_id",    bus.res_id,    '0);
        check("async_rst_req_ready", bus.req_ready, '0);
        sb.delete();
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        m_last = NREQ - 1;
        rr_mode = 1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            push_req(0, FCMP_LT, $urandom, $urandom);
            push_req(1, FCMP_LT, $urandom, $urandom);
        end
        pop_ids.delete();
        @(posedge clk); #1 rstn = 1'b1;
        drain("post_reset", 60);
        check("post_reset_count", 64'(pop_ids.size()), 64'd4);
        if (pop_ids.size() > 0)
            check("post_reset_first_id", 64'(pop_ids[0]), 64'd0);

        // Randomized traffic: gaps on requesters, random consumer stalls.
        gap_en  = 1'b1;
        rr_mode = 2;
        for (int k = 0; k < 300; k++) begin
            x = $urandom;
            case ($urandom_range(0, 4))
                0:       y = x;
                1:       y = x ^ 32'h8000_0000;
                2:       y = {x[31:23], 23'($urandom)};
                3:       y = {x[31], 8'($urandom), x[22:0]};
                default: y = $urandom;
            endcase
            push_req($urandom_range(0, NREQ - 1), fcmp_op_t'($urandom_range(0, 3)), x, y);
        end
        drain("random", 5000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
